// File: rtl/morse_letter_if.sv
// Letter handoff from the Morse sequencer to the translator: packed code word,
// symbol count and a valid/ready handshake.
interface morse_letter_if #(
  parameter int MAX_SYM = 5
);
  localparam int CODE_W = 2 * MAX_SYM;
  localparam int LEN_W  = $clog2(MAX_SYM + 1);

  logic [CODE_W-1:0] code;
  logic [LEN_W-1:0]  code_len;
  logic              code_valid;
  logic              code_ready;

  modport master (output code, output code_len, output code_valid, input code_ready);
  modport slave  (input code, input code_len, input code_valid, output code_ready);
endinterface

// File: rtl/morse_letter_sequencer.sv
// Times button presses and gaps, classifies presses as short/long, assembles
// the letter code word and offers it to the translator over valid/ready.
module morse_letter_sequencer #(
  parameter int CNT_W      = 17,
  parameter int SHORT_MAX  = 2000,
  parameter int LONG_MIN   = 4000,
  parameter int LONG_MAX   = 7000,
  parameter int LETTER_GAP = 7000,
  parameter int MAX_SYM    = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           btn_down,
  input  logic           btn_up,
  input  logic           del_pulse,
  input  logic           fin_pulse,
  morse_letter_if.master letter,
  output logic [1:0]     cur_class,
  output logic           overflow,
  output logic           err_pulse
);
  localparam int CODE_W = 2 * MAX_SYM;
  localparam int LEN_W  = $clog2(MAX_SYM + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(MAX_SYM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2,
    EMIT  = 2'd3
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CODE_W-1:0] code_r;
  logic [LEN_W-1:0]  len_r;
  logic              valid_r;
  logic [1:0]        class_r;
  logic              overflow_r;
  logic              err_r;

  logic [CNT_W-1:0]  cnt_inc_s;
  logic [1:0]        up_class_s;
  logic              handshake_s;

  // Press window for a given tick count: 01 short, 10 long, 11 too long, 00 otherwise.
  function automatic logic [1:0] press_class(input logic [CNT_W-1:0] cnt);
    logic [1:0] cls;
    if (cnt == '0) begin
      cls = 2'b00;
    end else if (cnt < CNT_W'(SHORT_MAX)) begin
      cls = 2'b01;
    end else if (cnt < CNT_W'(LONG_MIN)) begin
      cls = 2'b00;
    end else if (cnt <= CNT_W'(LONG_MAX)) begin
      cls = 2'b10;
    end else begin
      cls = 2'b11;
    end
    return cls;
  endfunction

  assign cnt_inc_s   = (tick && (cnt_r != CNT_SAT)) ? cnt_r + 1'b1 : cnt_r;
  assign up_class_s  = press_class(cnt_r);
  assign handshake_s = valid_r & letter.code_ready;

  // Sequencer FSM: counter, letter assembly, handshake and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      code_r     <= '0;
      len_r      <= '0;
      valid_r    <= 1'b0;
      class_r    <= 2'b00;
      overflow_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        IDLE, GAP: begin
          class_r <= 2'b00;
          if (state_r == GAP) begin
            cnt_r <= cnt_inc_s;
          end
          if (btn_down) begin
            state_r <= PRESS;
            cnt_r   <= '0;
          end else if (del_pulse) begin
            // A delete that empties the letter abandons the gap timer.
            if (len_r != '0) begin
              code_r <= code_r >> 2;
              len_r  <= len_r - 1'b1;
              if (len_r == LEN_W'(1)) begin
                state_r <= IDLE;
              end
            end
          end else if (fin_pulse && (len_r != '0)) begin
            state_r <= EMIT;
            valid_r <= 1'b1;
          end else if ((state_r == GAP) && (cnt_r >= CNT_W'(LETTER_GAP))) begin
            if (len_r != '0) begin
              state_r <= EMIT;
              valid_r <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        PRESS: begin
          if (btn_up) begin
            state_r <= GAP;
            cnt_r   <= '0;
            class_r <= 2'b00;
            case (up_class_s)
              2'b01, 2'b10: begin
                if (len_r == LEN_FULL) begin
                  overflow_r <= 1'b1;
                end else begin
                  code_r <= {code_r[CODE_W-3:0], 1'b1, up_class_s[1]};
                  len_r  <= len_r + 1'b1;
                end
              end
              default: err_r <= 1'b1;
            endcase
          end else begin
            cnt_r   <= cnt_inc_s;
            class_r <= press_class(cnt_inc_s);
          end
        end
        EMIT: begin
          class_r <= 2'b00;
          if (handshake_s) begin
            valid_r    <= 1'b0;
            code_r     <= '0;
            len_r      <= '0;
            overflow_r <= 1'b0;
            err_r      <= del_pulse | fin_pulse;
            // A press arriving with the accept starts the next letter immediately.
            if (btn_down) begin
              state_r <= PRESS;
              cnt_r   <= '0;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            err_r <= btn_down | del_pulse | fin_pulse;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign letter.code       = code_r;
  assign letter.code_len   = len_r;
  assign letter.code_valid = valid_r;
  assign cur_class         = class_r;
  assign overflow          = overflow_r;
  assign err_pulse         = err_r;

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Scoreboard bench for morse_letter_sequencer: a symbol-queue reference model
// predicts letters, a negedge monitor checks every handshake and error pulse.
module tb_morse_letter_sequencer;
  localparam int SHORT_MAX  = 2000;
  localparam int LONG_MIN   = 4000;
  localparam int LONG_MAX   = 7000;
  localparam int LETTER_GAP = 7000;
  localparam int MAX_SYM    = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic btn_down = 1'b0;
  logic btn_up = 1'b0;
  logic del_pulse = 1'b0;
  logic fin_pulse = 1'b0;
  logic [1:0] cur_class;
  logic overflow;
  logic err_pulse;

  morse_letter_if #(.MAX_SYM(MAX_SYM)) lif();

  morse_letter_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .btn_down  (btn_down),
    .btn_up    (btn_up),
    .del_pulse (del_pulse),
    .fin_pulse (fin_pulse),
    .letter    (lif),
    .cur_class (cur_class),
    .overflow  (overflow),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int len;
    int ov;
  } exp_t;

  exp_t sb_q[$];
  int   syms[$];      // symbols of the letter being built, oldest first; 2=short, 3=long
  int   ov_m = 0;
  bit   in_emit = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   err_seen = 0;
  int   err_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  function automatic int ref_class(input int n);
    if (n >= 1 && n < SHORT_MAX) return 1;
    if (n >= LONG_MIN && n <= LONG_MAX) return 2;
    if (n > LONG_MAX) return 3;
    return 0;
  endfunction

  function automatic int ref_code();
    int c = 0;
    foreach (syms[i]) c = c * 4 + syms[i];
    return c;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    btn_down  = 1'b0;
    btn_up    = 1'b0;
    del_pulse = 1'b0;
    fin_pulse = 1'b0;
  endtask

  task automatic push_letter();
    exp_t e;
    e.code = ref_code();
    e.len  = syms.size();
    e.ov   = ov_m;
    sb_q.push_back(e);
    in_emit = 1'b1;
  endtask

  // Hold the button for n ticks (state already PRESS), then release.
  task automatic press_body(input int n);
    int c;
    tick = 1'b1;
    for (int i = 1; i <= n; i++) begin
      cyc();
      chk("cur_class", cur_class, ref_class(i));
    end
    tick = 1'b0;
    btn_up = 1'b1;
    cyc();
    c = ref_class(n);
    if (c == 1 || c == 2) begin
      if (syms.size() == MAX_SYM) ov_m = 1;
      else syms.push_back(c == 1 ? 2 : 3);
    end else begin
      err_exp++;
    end
    chk("press_code", lif.code, ref_code());
    chk("press_len", lif.code_len, syms.size());
    chk("press_overflow", overflow, ov_m);
    chk("class_after_up", cur_class, 0);
  endtask

  task automatic press(input int n);
    btn_down = 1'b1;
    cyc();
    chk("class_at_down", cur_class, 0);
    press_body(n);
  endtask

  task automatic do_del();
    del_pulse = 1'b1;
    cyc();
    if (syms.size() > 0) void'(syms.pop_back());
    chk("del_code", lif.code, ref_code());
    chk("del_len", lif.code_len, syms.size());
  endtask

  task automatic do_fin();
    fin_pulse = 1'b1;
    cyc();
    if (syms.size() > 0) begin
      chk("fin_valid", lif.code_valid, 1);
      push_letter();
    end else begin
      chk("fin_empty_novalid", lif.code_valid, 0);
    end
  endtask

  task automatic wait_gap();
    int k = 0;
    tick = 1'b1;
    while (k < LETTER_GAP + 10 && !lif.code_valid) begin
      cyc();
      k++;
    end
    tick = 1'b0;
    if (syms.size() > 0) begin
      chk("gap_latency", k, LETTER_GAP + 1);
      chk("gap_valid", lif.code_valid, 1);
      push_letter();
    end else begin
      chk("gap_empty_novalid", lif.code_valid, 0);
    end
  endtask

  task automatic accept(input bit with_btn);
    lif.code_ready = 1'b1;
    btn_down = with_btn;
    cyc();
    lif.code_ready = 1'b0;
    syms.delete();
    ov_m = 0;
    in_emit = 1'b0;
    chk("hs_valid", lif.code_valid, 0);
    chk("hs_code", lif.code, 0);
    chk("hs_len", lif.code_len, 0);
    chk("hs_overflow", overflow, 0);
  endtask

  task automatic chk_err(input string name);
    cyc();
    chk(name, err_seen, err_exp);
  endtask

  task automatic reset_now();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_code", lif.code, 0);
    chk("rst_len", lif.code_len, 0);
    chk("rst_valid", lif.code_valid, 0);
    chk("rst_class", cur_class, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_err", err_pulse, 0);
    tick = 1'b0;
    syms.delete();
    ov_m = 0;
    in_emit = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int rand_len();
    int r = $urandom_range(0, 99);
    int b[7] = '{1, SHORT_MAX - 1, SHORT_MAX, LONG_MIN - 1, LONG_MIN, LONG_MAX, LONG_MAX + 1};
    if (r < 45) return $urandom_range(1, SHORT_MAX - 1);
    if (r < 65) return b[$urandom_range(0, 6)];
    if (r < 80) return $urandom_range(LONG_MIN, LONG_MAX);
    if (r < 88) return $urandom_range(SHORT_MAX, LONG_MIN - 1);
    if (r < 94) return 0;
    return $urandom_range(LONG_MAX + 1, LONG_MAX + 200);
  endfunction

  // Monitor: counts error pulses and scores every handshake against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && err_pulse) err_seen++;
    if (rst_n && lif.code_valid && lif.code_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: handshake with code %0d, expected no letter", lif.code);
      end else begin
        e = sb_q.pop_front();
        chk("sb_code", lif.code, e.code);
        chk("sb_len", lif.code_len, e.len);
        chk("sb_overflow", overflow, e.ov);
      end
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    lif.code_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_code", lif.code, 0);
    chk("reset_len", lif.code_len, 0);
    chk("reset_valid", lif.code_valid, 0);
    chk("reset_class", cur_class, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_err", err_pulse, 0);
    rst_n = 1'b1;
    cyc();

    // Short then long, letter closed by the gap timer.
    press(1000);
    press(5000);
    wait_gap();
    chk("tp1_code", lif.code, 32'b0000001011);
    chk("tp1_len", lif.code_len, 2);
    accept(1'b0);

    // Ambiguous and too-long presses are rejected.
    press(3000);
    press(8000);
    chk("tp2_len", lif.code_len, 0);
    chk_err("tp2_err");

    // Six shorts overflow a five-symbol letter.
    for (int i = 0; i < 6; i++) press(100);
    do_fin();
    chk("tp3_code", lif.code, 32'b1010101010);
    chk("tp3_overflow_emit", overflow, 1);
    accept(1'b0);

    // Delete, finish, and delete on an empty letter.
    press(500);
    press(5000);
    do_del();
    do_fin();
    chk("tp4_code", lif.code, 32'b0000000010);
    chk("tp4_len", lif.code_len, 1);
    accept(1'b0);
    do_del();
    chk_err("tp4_err");

    // Events during EMIT are dropped; a press with the accept is honoured.
    press(300);
    press(4500);
    do_fin();
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin btn_down = 1'b1; err_exp++; end
      if (i == 30) begin del_pulse = 1'b1; err_exp++; end
      cyc();
    end
    chk("tp5_code_stable", lif.code, ref_code());
    chk("tp5_valid_held", lif.code_valid, 1);
    chk_err("tp5_err");
    accept(1'b1);
    press_body(700);
    chk("tp5_next_len", lif.code_len, 1);

    // Asynchronous reset during PRESS and during EMIT.
    btn_down = 1'b1;
    cyc();
    tick = 1'b1;
    repeat (500) cyc();
    reset_now();
    press(1000);
    chk("tp6_len_a", lif.code_len, 1);
    do_fin();
    reset_now();
    press(1000);
    chk("tp6_len_b", lif.code_len, 1);
    do_fin();
    accept(1'b0);

    // Randomized mix of presses, deletes, finishes, gap expiries and accepts.
    for (int it = 0; it < 14; it++) begin
      int r = $urandom_range(0, 99);
      if (in_emit) begin
        if (r < 70) begin
          accept(1'b0);
        end else begin
          del_pulse = 1'b1;
          err_exp++;
          cyc();
          chk("rnd_emit_code", lif.code, ref_code());
          chk("rnd_emit_valid", lif.code_valid, 1);
        end
      end else if (r < 60) begin
        press(rand_len());
      end else if (r < 75) begin
        do_del();
      end else if (r < 90) begin
        do_fin();
      end else begin
        wait_gap();
      end
    end
    if (in_emit) accept(1'b0);

    chk_err("final_err");
    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_letter_sequencer.md
Name: morse_letter_sequencer

Overview:
- Controls the Morse letter-capture datapath: takes debounced button-edge pulses plus a time-base tick, times presses and gaps, and classifies each press as short or long.
- Assembles up to MAX_SYM symbols into a 2-bit-per-symbol code word and applies delete requests.
- Hands the finished letter to the downstream translator over a valid/ready handshake.
- Sits between the three Debouncer instances and the letter translator.

Parameters:
CNT_W, 17, width of the tick counter; saturates at 2^CNT_W-1
SHORT_MAX, 2000, press of 1..SHORT_MAX-1 ticks = short symbol
LONG_MIN, 4000, lower bound (inclusive) of long press
LONG_MAX, 7000, upper bound (inclusive) of long press
LETTER_GAP, 7000, release ticks that auto-terminate a non-empty letter
MAX_SYM, 5, maximum symbols per letter (code width = 2*MAX_SYM)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
tick  input  1  one-cycle time-base strobe
btn_down  input  1  one-cycle pulse, main button pressed
btn_up  input  1  one-cycle pulse, main button released
del_pulse  input  1  one-cycle pulse, delete last symbol
fin_pulse  input  1  one-cycle pulse, finish letter now
code  output  10  packed letter; newest symbol in [1:0]; 10=short, 11=long, 00=empty slot
code_len  output  3  number of valid symbols (0..MAX_SYM)
code_valid  output  1  letter offered downstream
code_ready  input  1  downstream accepts letter
cur_class  output  2  live press class: 00 none/too-short-window, 01 short window, 10 long window, 11 too long
overflow  output  1  sticky; symbol dropped because letter was full; cleared on handshake
err_pulse  output  1  one-cycle pulse on a rejected press (ambiguous, too long, or event during EMIT)

Behaviour:
- Reset (async assert, sync-safe release): state IDLE; code=0, code_len=0, code_valid=0, cur_class=00, overflow=0, err_pulse=0, counter=0.
- States: IDLE, PRESS, GAP, EMIT.
- Counter: cleared on entry to PRESS or GAP; +1 on each tick while in PRESS/GAP; saturates, never wraps.
- IDLE:
  - btn_down -> PRESS.
  - del_pulse: if code_len>0, code <= code>>2 and code_len-1; else no-op.
  - fin_pulse with code_len>0 -> EMIT; with code_len=0, ignored.
  - del has priority over fin in the same cycle; fin is then ignored.
- PRESS:
  - cur_class tracks the counter: 01 for 1..SHORT_MAX-1; 00 for 0 and for SHORT_MAX..LONG_MIN-1; 10 for LONG_MIN..LONG_MAX; 11 above LONG_MAX.
  - del_pulse and fin_pulse are ignored.
  - On btn_up, classify by counter value:
    - short -> append 10;
    - long -> append 11;
    - 0 ticks, ambiguous (SHORT_MAX..LONG_MIN-1) or >LONG_MAX -> nothing appended, err_pulse=1.
  - Append: code <= {code[7:0], sym}, code_len+1. If code_len==MAX_SYM, the symbol is dropped and overflow is set.
  - After btn_up -> GAP; cur_class returns to 00 on the following cycle.
- GAP:
  - btn_down -> PRESS.
  - del and fin as in IDLE; a del that brings code_len to 0 -> IDLE.
  - Counter reaching LETTER_GAP: with code_len>0 -> EMIT; with code_len=0 -> IDLE.
  - btn_down takes priority over gap expiry in the same cycle.
- EMIT:
  - code_valid=1; code and code_len held stable until handshake.
  - Handshake = code_valid & code_ready in the same cycle.
  - On handshake: code_valid=0, code=0, code_len=0, overflow=0 -> IDLE.
  - btn_down, del_pulse and fin_pulse are dropped, each with err_pulse=1.
  - Exception: btn_down in the handshake cycle is honoured and the next state is PRESS, with the letter already cleared.
- Latency: btn_up -> updated code/code_len visible next cycle. fin_pulse -> code_valid high next cycle.
- Reset mid-operation aborts everything, including a pending EMIT; the letter is lost.

Test Plan:
- Press held 1000 ticks, release; repeat with 5000 ticks; wait LETTER_GAP ticks -> code=0000001011, code_len=2, code_valid=1; ready pulse -> code=0, code_len=0, state IDLE.
- Press 3000 ticks (ambiguous), then press 8000 ticks -> err_pulse on each release, code_len stays 0; cur_class reads 00, 01, 00, 10, 11 as the 8000-tick hold passes the thresholds.
- Six short presses then fin_pulse -> code=1010101010, code_len=5, overflow=1 while code_valid=1; overflow cleared after handshake.
- Short, long, del_pulse, fin_pulse -> code=0000000010, code_len=1; del_pulse with code_len=0 -> no change, no error.
- In EMIT with code_ready=0 for 50 cycles, inject btn_down and del_pulse -> code stable, err_pulse twice; then code_ready=1 with btn_down in the same cycle -> handshake completes, next state PRESS.
- rst_n asserted low during PRESS and during EMIT -> all outputs zero immediately (asynchronous); after release, a 1000-tick press yields code_len=1.
